ibex_hpm_counter_bank: RTL and testbench

- Parametrised bank of machine hardware performance monitor counters, mhpmcounter3 onwards, with matching mhpmevent selectors.
- Generalises the fixed per-counter logic to N counters of configurable width.
- Adds event masking, sticky overflow status and an optional overflow interrupt.
- Sits beside the CSR file in the ID/EX stage. It decodes its own CSR addresses and supplies read data to the CSR read mux.

---
 rtl/ibex_hpm_counter_bank.sv | 96 +++++++++
 tb/tb_ibex_hpm_counter_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ibex_hpm_counter_bank.sv
// ibex_hpm_counter_bank: mhpmcounter3+/mhpmevent3+ bank with sticky overflow flags.
// Define IBEX_HPM_OVERFLOW_IRQ_EN to add the overflow enable CSR (0x7C1) and interrupt.
module ibex_hpm_counter_bank #(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumEvents-1:0]   events_i,
    input  logic [NumCounters-1:0] inhibit_i,
    input  logic                   csr_we_i,
    input  logic [11:0]            csr_addr_i,
    input  logic [31:0]            csr_wdata_i,
    output logic                   csr_hit_o,
    output logic [31:0]            csr_rdata_o,
    output logic [NumCounters-1:0] ovf_pending_o,
    output logic                   ovf_irq_o
);
    logic [NumCounters-1:0] hit_lo, hit_hi, hit_ev;
    logic [31:0]            rd_lo [NumCounters];
    logic [31:0]            rd_hi [NumCounters];
    logic [31:0]            rd_ev [NumCounters];
    logic                   hit_en;
    logic [31:0]            rd_en;

    always_comb begin
        for (int i = 0; i < int'(NumCounters); i++) begin
            hit_lo[i] = csr_addr_i == 12'(32'hB03 + i);
            hit_hi[i] = csr_addr_i == 12'(32'hB83 + i);
            hit_ev[i] = csr_addr_i == 12'(32'h323 + i);
        end
    end

    for (genvar c = 0; c < int'(NumCounters); c++) begin : g_ctr
        logic [CounterWidth-1:0] cnt_q;
        logic [NumEvents-1:0]    evt_q;
        logic                    ovf_q;
        logic [63:0]             ext, wr_val;
        logic                    wr, inc;
        // Counter is handled as a zero-extended 64-bit value so both halves
        // read and write uniformly for any width; truncation drops unused bits.
        assign ext    = 64'(cnt_q);
        assign wr     = csr_we_i & (hit_lo[c] | hit_hi[c]);
        assign inc    = |(evt_q & events_i) & ~inhibit_i[c];
        assign wr_val = hit_lo[c] ? {ext[63:32], csr_wdata_i} : {csr_wdata_i, ext[31:0]};
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                evt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (wr) cnt_q <= wr_val[CounterWidth-1:0];
                else if (inc) cnt_q <= cnt_q + CounterWidth'(1);
                if (wr) ovf_q <= 1'b0;
                else if (inc && &cnt_q) ovf_q <= 1'b1;
                if (csr_we_i && hit_ev[c]) evt_q <= csr_wdata_i[NumEvents-1:0];
            end
        end
        assign rd_lo[c]         = ext[31:0];
        assign rd_hi[c]         = ext[63:32];
        assign rd_ev[c]         = 32'(evt_q);
        assign ovf_pending_o[c] = ovf_q;
    end

`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
    logic [NumCounters-1:0] en_q;
    logic                   irq_q;
    assign hit_en = csr_addr_i == 12'h7C1;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (csr_we_i && hit_en) en_q <= csr_wdata_i[NumCounters-1:0];
            irq_q <= |(ovf_pending_o & en_q);
        end
    end
    assign rd_en     = 32'(en_q);
    assign ovf_irq_o = irq_q;
`else
    assign hit_en    = 1'b0;
    assign rd_en     = '0;
    assign ovf_irq_o = 1'b0;
`endif

    always_comb begin
        csr_hit_o   = hit_en | (|hit_lo) | (|hit_hi) | (|hit_ev);
        csr_rdata_o = hit_en ? rd_en : '0;
        for (int i = 0; i < int'(NumCounters); i++) begin
            csr_rdata_o = csr_rdata_o | (hit_lo[i] ? rd_lo[i] : '0)
                                      | (hit_hi[i] ? rd_hi[i] : '0)
                                      | (hit_ev[i] ? rd_ev[i] : '0);
        end
    end
endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// tb_ibex_hpm_counter_bank: directed checks of the HPM counter bank (default parameters).
module tb_ibex_hpm_counter_bank;
`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
    localparam logic IrqEn = 1'b1;
`else
    localparam logic IrqEn = 1'b0;
`endif
    logic        clk, rst_n, csr_we, csr_hit, ovf_irq;
    logic [15:0] events;
    logic [7:0]  inhibit, ovf_pending;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    int          n_chk = 0, n_fail = 0;

    ibex_hpm_counter_bank dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .events_i     (events),
        .inhibit_i    (inhibit),
        .csr_we_i     (csr_we),
        .csr_addr_i   (csr_addr),
        .csr_wdata_i  (csr_wdata),
        .csr_hit_o    (csr_hit),
        .csr_rdata_o  (csr_rdata),
        .ovf_pending_o(ovf_pending),
        .ovf_irq_o    (ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic exp_hit,
                          input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, {csr_hit, csr_rdata}, {exp_hit, exp});
    endtask

    initial begin
        rst_n = 1'b0; events = '0; inhibit = '0;
        csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_rd("rst_cnt", 12'hB03, 1'b1, 32'h0);
        chk_rd("rst_evt", 12'h323, 1'b1, 32'h0);
        chk_rd("rst_cnth", 12'hB83, 1'b1, 32'h0);
        chk_rd("miss_b00", 12'hB00, 1'b0, 32'h0);
        check("rst_ovf", ovf_pending, 8'h00);
        check("rst_irq", ovf_irq, 1'b0);

        wr(12'h323, 32'h5);
        events = 16'h0004;
        repeat (10) tick();
        chk_rd("cnt_sel", 12'hB03, 1'b1, 32'd10);
        events = 16'h0002;
        repeat (3) tick();
        chk_rd("cnt_unsel", 12'hB03, 1'b1, 32'd10);
        events = 16'h0005;
        repeat (3) tick();
        events = '0;
        chk_rd("cnt_multi", 12'hB03, 1'b1, 32'd13);

        wr(12'hB03, 32'h0);
        inhibit = 8'h01;
        events  = 16'h0004;
        repeat (10) tick();
        chk_rd("inhibit", 12'hB03, 1'b1, 32'h0);
        wr(12'hB03, 32'h7);
        tick();
        chk_rd("inh_wr", 12'hB03, 1'b1, 32'h7);
        events = '0; inhibit = '0;

        chk_rd("evt_rd", 12'h323, 1'b1, 32'h5);
        wr(12'h323, 32'hFFFF_FFFF);
        chk_rd("evt_trunc", 12'h323, 1'b1, 32'h0000_FFFF);
        wr(12'h323, 32'h1);
        chk_rd("evt_keep_cnt", 12'hB03, 1'b1, 32'h7);

        wr(12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFE);
        chk_rd("hi_wr", 12'hB83, 1'b1, 32'hFF);
        chk_rd("lo_wr", 12'hB03, 1'b1, 32'hFFFF_FFFE);
        events = 16'h0001;
        tick();
        chk_rd("pre_wrap", 12'hB03, 1'b1, 32'hFFFF_FFFF);
        check("pre_wrap_ovf", ovf_pending, 8'h00);
        tick();
        chk_rd("wrap_lo", 12'hB03, 1'b1, 32'h0);
        chk_rd("wrap_hi", 12'hB83, 1'b1, 32'h0);
        check("wrap_ovf", ovf_pending, 8'h01);
        wr(12'hB03, 32'h10);
        chk_rd("wr_wins", 12'hB03, 1'b1, 32'h10);
        check("wr_clr_ovf", ovf_pending, 8'h00);
        tick();
        chk_rd("post_wr_inc", 12'hB03, 1'b1, 32'h11);
        events = '0;

        wr(12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        events = 16'h0001;
        wr(12'hB03, 32'h5);
        events = '0;
        chk_rd("ovf_vs_wr", 12'hB03, 1'b1, 32'h5);
        chk_rd("lo_keeps_hi", 12'hB83, 1'b1, 32'hFF);
        check("ovf_vs_wr_flag", ovf_pending, 8'h00);

`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
        wr(12'h7C1, 32'h2);
        chk_rd("en_rd", 12'h7C1, 1'b1, 32'h2);
`else
        chk_rd("en_miss", 12'h7C1, 1'b0, 32'h0);
`endif
        wr(12'h324, 32'h1);
        wr(12'h325, 32'h1);
        wr(12'hB84, 32'hFF);
        wr(12'hB04, 32'hFFFF_FFFF);
        wr(12'hB85, 32'hFF);
        wr(12'hB05, 32'hFFFF_FFFF);
        events = 16'h0001;
        tick();
        events = '0;
        check("multi_ovf", ovf_pending, 8'h06);
        check("irq_delay", ovf_irq, 1'b0);
        tick();
        check("irq_rise", ovf_irq, IrqEn);
        wr(12'hB84, 32'h0);
        check("clr_one", ovf_pending, 8'h04);
        check("irq_hold", ovf_irq, IrqEn);
        tick();
        check("irq_fall", ovf_irq, 1'b0);
        wr(12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        events = 16'h0001;
        tick();
        events = '0;
        check("ovf0_masked", ovf_pending, 8'h05);
        tick();
        check("irq_masked", ovf_irq, 1'b0);

        wr(12'hB84, 32'hFF);
        wr(12'hB04, 32'hFFFF_FFFF);
        events = 16'h0001;
        wr(12'hB03, 32'h1234);
        chk_rd("mid_count", 12'hB03, 1'b1, 32'h1234);
        check("mid_ovf", ovf_pending, 8'h06);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ovf", ovf_pending, 8'h00);
        check("arst_irq", ovf_irq, 1'b0);
        chk_rd("arst_cnt0", 12'hB03, 1'b1, 32'h0);
        chk_rd("arst_cnt1", 12'hB04, 1'b1, 32'h0);
        chk_rd("arst_evt", 12'h323, 1'b1, 32'h0);
        events = '0;
        tick();
        rst_n = 1'b1;
        tick();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
